// File: rtl/fir_out_buffer.sv
// Output elastic buffer behind the FIR: a first-word fall-through FIFO plus a frame-length checker.
// Latency: a pushed sample is visible on m_tvalid/m_tdata one cycle after the push edge.
// Backpressure: s_tready = (fill < pDEPTH); the checker only observes pushes and never stalls data.
module fir_out_buffer #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst_n,
    // upstream stream (from FIR sm_* side)
    input  logic                       s_tvalid,
    input  logic [pDATA_WIDTH-1:0]     s_tdata,
    input  logic                       s_tlast,
    output logic                       s_tready,
    // downstream stream
    output logic                       m_tvalid,
    output logic [pDATA_WIDTH-1:0]     m_tdata,
    output logic                       m_tlast,
    input  logic                       m_tready,
    // frame checker control/status
    input  logic                       cfg_start,
    input  logic [31:0]                cfg_len,
    output logic                       frame_done,
    output logic                       len_err,
    // occupancy
    output logic [$clog2(pDEPTH):0]    fill
);

    localparam int AW = $clog2(pDEPTH);

    // Occupancy and pointer constants sized to their targets to keep arithmetic width-exact.
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(pDEPTH);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Each entry carries {tlast, tdata}.
    logic [pDATA_WIDTH:0] mem [pDEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [pDATA_WIDTH:0] head;

    logic push;
    logic pop;

    state_t      state;
    logic [31:0] beat_cnt;
    logic [31:0] len_q;
    logic [31:0] beat_next;
    logic        len_match;
    logic        frame_end;

    // Handshakes: ready depends only on occupancy so the FIR output never sees a loop through s_tvalid.
    assign s_tready = (fill < DEPTH_V);
    assign m_tvalid = (fill != '0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    // Head entry is gated by m_tvalid so stale or uninitialised storage never shows on an empty buffer.
    assign head    = mem[rd_ptr];
    assign m_tdata = m_tvalid ? head[pDATA_WIDTH-1:0] : '0;
    assign m_tlast = m_tvalid ? head[pDATA_WIDTH]     : 1'b0;

    // Storage write; contents need no reset because the output is masked while empty.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    // Pointers wrap naturally at pDEPTH because the depth is a power of two.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy: simultaneous push and pop leave fill unchanged.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            fill <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase
        end
    end

    // Beat count after the current push, and whether that push closes the frame.
    // A zero length can never be matched, so the first counted push ends the frame as an error.
    assign beat_next = beat_cnt + 32'd1;
    assign len_match = (beat_next == len_q);
    assign frame_end = s_tlast | len_match | (len_q == 32'd0);

    // Frame checker: counts pushes in RUN and flags tlast/length disagreement on frame end.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            len_q      <= '0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cfg_start) begin
                        state      <= RUN;
                        len_q      <= cfg_len;
                        beat_cnt   <= '0;
                        len_err    <= 1'b0;
                        frame_done <= 1'b0;
                    end
                end
                RUN: begin
                    if (push) begin
                        beat_cnt <= beat_next;
                        if (frame_end) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            len_err    <= ~(s_tlast & len_match);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    len_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_out_buffer.sv
module tb_fir_out_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          axis_clk;
    logic          axis_rst_n;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready;
    logic          cfg_start;
    logic [31:0]   cfg_len;
    logic          frame_done;
    logic          len_err;
    logic [3:0]    fill;

    int checks;
    int failures;

    // expected beats: {tlast, tdata}
    logic [DW:0] exp_q [$];

    fir_out_buffer #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .frame_done (frame_done),
        .len_err    (len_err),
        .fill       (fill)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output beat accepted downstream is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge axis_clk);
            if (axis_rst_n && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got data 0x%0h last %0b with no beat expected", m_tdata, m_tlast);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", 64'(m_tdata), 64'(e[DW-1:0]));
                    chk("out_last", 64'(m_tlast), 64'(e[DW]));
                end
            end
        end
    end

    // Offer one sample and hold it until accepted; the scoreboard entry is queued on acceptance.
    task automatic send(input logic [DW-1:0] d, input logic l);
        bit done;
        done = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge axis_clk);
            if (s_tready) begin
                exp_q.push_back({l, d});
                done = 1;
            end
            @(posedge axis_clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: sample 0x%0h never accepted", d);
        end
    endtask

    task automatic idle_in();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic start_frame(input logic [31:0] len);
        cfg_start = 1'b1;
        cfg_len   = len;
        @(posedge axis_clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        for (int i = 0; i < 200 && !empty; i++) begin
            @(negedge axis_clk);
            if (fill == 0) empty = 1;
        end
        if (!empty) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: fill stuck at %0d", fill);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        axis_rst_n = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        cfg_start  = 1'b0;
        cfg_len    = '0;
        #22;
        axis_rst_n = 1'b1;

        // reset state
        @(negedge axis_clk);
        chk("rst_s_tready",   64'(s_tready),   64'd1);
        chk("rst_m_tvalid",   64'(m_tvalid),   64'd0);
        chk("rst_fill",       64'(fill),       64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_len_err",    64'(len_err),    64'd0);
        chk("rst_m_tdata",    64'(m_tdata),    64'd0);
        chk("rst_m_tlast",    64'(m_tlast),    64'd0);
        @(posedge axis_clk);
        #1;

        // exact-length frame of 4 samples
        m_tready = 1'b1;
        start_frame(32'd4);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        chk("len4_not_done_early", 64'(frame_done), 64'd0);
        send(32'd4, 1'b1);
        idle_in();
        @(negedge axis_clk);
        chk("len4_frame_done", 64'(frame_done), 64'd1);
        chk("len4_len_err",    64'(len_err),    64'd0);
        drain();

        // fill to capacity with downstream stalled, then release
        @(posedge axis_clk);
        #1;
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(32'h100 + 32'(i), 1'b0);
        idle_in();
        @(negedge axis_clk);
        chk("full_fill",     64'(fill),     64'd8);
        chk("full_s_tready", 64'(s_tready), 64'd0);
        chk("full_head",     64'(m_tdata),  64'h100);
        @(negedge axis_clk);
        chk("stall_head_stable", 64'(m_tdata), 64'h100);
        @(posedge axis_clk);
        #1;
        m_tready = 1'b1;
        send(32'h108, 1'b1);
        idle_in();
        drain();

        // tlast arrives early: length 5, tlast on the 3rd
        @(posedge axis_clk);
        #1;
        start_frame(32'd5);
        send(32'h21, 1'b0);
        send(32'h22, 1'b0);
        send(32'h23, 1'b1);
        idle_in();
        @(negedge axis_clk);
        chk("early_last_done", 64'(frame_done), 64'd1);
        chk("early_last_err",  64'(len_err),    64'd1);
        @(posedge axis_clk);
        #1;
        send(32'h24, 1'b1);
        send(32'h25, 1'b0);
        idle_in();
        @(negedge axis_clk);
        chk("early_last_hold_done", 64'(frame_done), 64'd1);
        chk("early_last_hold_err",  64'(len_err),    64'd1);
        drain();

        // missing tlast: length 2, no tlast; a 3rd sample still flows
        @(posedge axis_clk);
        #1;
        start_frame(32'd2);
        @(negedge axis_clk);
        chk("restart_clears_done", 64'(frame_done), 64'd0);
        @(posedge axis_clk);
        #1;
        send(32'h31, 1'b0);
        send(32'h32, 1'b0);
        idle_in();
        @(negedge axis_clk);
        chk("no_last_done", 64'(frame_done), 64'd1);
        chk("no_last_err",  64'(len_err),    64'd1);
        @(posedge axis_clk);
        #1;
        send(32'h33, 1'b0);
        idle_in();
        drain();

        // zero length: first counted push ends the frame in error
        @(posedge axis_clk);
        #1;
        start_frame(32'd0);
        send(32'h41, 1'b0);
        idle_in();
        @(negedge axis_clk);
        chk("len0_done", 64'(frame_done), 64'd1);
        chk("len0_err",  64'(len_err),    64'd1);
        drain();

        // continuous streaming: fill stays at 1 while pointers wrap
        @(posedge axis_clk);
        #1;
        for (int i = 0; i < 21; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h500 + 32'(i);
            s_tlast  = (i == 20);
            @(negedge axis_clk);
            if (i > 0) chk("stream_fill", 64'(fill), 64'd1);
            chk("stream_s_tready", 64'(s_tready), 64'd1);
            exp_q.push_back({s_tlast, s_tdata});
            @(posedge axis_clk);
            #1;
        end
        idle_in();
        drain();

        // asynchronous reset mid-frame with three samples buffered
        @(posedge axis_clk);
        #1;
        m_tready = 1'b0;
        start_frame(32'd10);
        send(32'h61, 1'b0);
        send(32'h62, 1'b0);
        send(32'h63, 1'b0);
        idle_in();
        @(negedge axis_clk);
        chk("pre_rst_fill", 64'(fill), 64'd3);
        #2;
        axis_rst_n = 1'b0;
        #1;
        chk("async_rst_m_tvalid",   64'(m_tvalid),   64'd0);
        chk("async_rst_fill",       64'(fill),       64'd0);
        chk("async_rst_frame_done", 64'(frame_done), 64'd0);
        chk("async_rst_m_tdata",    64'(m_tdata),    64'd0);
        exp_q.delete();
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        chk("post_rst_s_tready", 64'(s_tready), 64'd1);
        chk("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);

        repeat (3) @(posedge axis_clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
